// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a short in-order pipeline. It resolves three hazard
// kinds in fixed priority order:
//   1. memory stall  - the MEM stage is waiting on memory (whole pipe frozen)
//   2. load-use      - the ID instruction needs the result of the load in EX
//                      (PC and IF/ID held, a bubble goes into EX)
//   3. taken branch  - the IF/ID instruction is squashed for BR_PENALTY cycles
// A memory wait that lasts too long is abandoned and mem_timeout is latched
// until reset. After that, memory requests no longer stall the pipe.
//
// Parameters
//   TIMEOUT     maximum stalled MEM_WAIT cycles before giving up (2..255)
//   BR_PENALTY  flush cycles per taken branch (1..15)
//   CNTW        width of the saturating stall counter
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_valid                       ID stage holds a valid instruction
//   id_ropa/id_ropb                ID source register addresses
//   id_ropa_is_reg/id_ropb_is_reg  operand really reads a register
//   id_branch                      ID instruction is a taken branch
//   ex_valid, ex_memrd, ex_rd      EX valid, EX is a load, EX destination
//   mem_req, mem_ready             MEM request and memory acknowledge
//   stall_if, stall_id             hold PC + IF/ID, hold ID/EX
//   bubble_ex                      insert a NOP into EX
//   stall_mem                      freeze EX/MEM/WB
//   flush_id                       squash the IF/ID instruction
//   mem_timeout                    sticky memory-timeout flag
//   stall_count                    saturating count of stall_if cycles
//   state                          RUN=0, MEM_WAIT=1, BR_FLUSH=2
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT    = 16,
    parameter int BR_PENALTY = 1,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [3:0]      id_ropa,
    input  logic [3:0]      id_ropb,
    input  logic            id_ropa_is_reg,
    input  logic            id_ropb_is_reg,
    input  logic            id_branch,
    input  logic            ex_valid,
    input  logic            ex_memrd,
    input  logic [3:0]      ex_rd,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            stall_mem,
    output logic            flush_id,
    output logic            mem_timeout,
    output logic [CNTW-1:0] stall_count,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2,
        ILLEGAL  = 2'd3
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] BR_LOAD   = 4'(BR_PENALTY - 1);

    state_e          state_q, state_d;
    logic [3:0]      br_cnt_q, br_cnt_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic [CNTW-1:0] stall_count_q;

    logic memstall;
    logic loaduse;

    // Once the timeout flag is set, memory requests can no longer stall.
    assign memstall = mem_req & ~mem_ready & ~mem_timeout_q;

    // Register 15 is never a real load destination, so it cannot create a hazard.
    assign loaduse = ex_valid & ex_memrd & id_valid & (ex_rd != 4'd15) &
                     ((id_ropa_is_reg & (id_ropa == ex_rd)) |
                      (id_ropb_is_reg & (id_ropb == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            br_cnt_q      <= 4'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            br_cnt_q      <= br_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            if (stall_if && (stall_count_q != {CNTW{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        br_cnt_d      = br_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        bubble_ex     = 1'b0;
        stall_mem     = 1'b0;
        flush_id      = 1'b0;

        // Combinational outputs are gated so they read 0 throughout reset.
        if (rst_n) begin
            if (state_q == ILLEGAL) begin
                state_d  = RUN;
                br_cnt_d = 4'd0;
                if (memstall) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_mem = 1'b1;
                end
            end else if (memstall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_mem = 1'b1;
                // br_cnt is left untouched so an interrupted branch flush
                // resumes once memory answers.
                if (state_q == MEM_WAIT) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        mem_timeout_d = 1'b1;
                        state_d       = RUN;
                        wait_cnt_d    = 8'd0;
                        br_cnt_d      = 4'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (loaduse) begin
                            stall_if  = 1'b1;
                            stall_id  = 1'b1;
                            bubble_ex = 1'b1;
                        end else if (id_valid && id_branch) begin
                            flush_id = 1'b1;
                            if (BR_PENALTY > 1) begin
                                state_d  = BR_FLUSH;
                                br_cnt_d = BR_LOAD;
                            end
                        end
                    end
                    MEM_WAIT: begin
                        // Memory answered (or the request went away): release.
                        wait_cnt_d = 8'd0;
                        state_d    = (br_cnt_q != 4'd0) ? BR_FLUSH : RUN;
                    end
                    BR_FLUSH: begin
                        flush_id = 1'b1;
                        if (br_cnt_q <= 4'd1) begin
                            state_d  = RUN;
                            br_cnt_d = 4'd0;
                        end else begin
                            br_cnt_d = br_cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = RUN;
                    end
                endcase
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_ropa;
    logic [3:0]  id_ropb;
    logic        id_ropa_is_reg;
    logic        id_ropb_is_reg;
    logic        id_branch;
    logic        ex_valid;
    logic        ex_memrd;
    logic [3:0]  ex_rd;
    logic        mem_req;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        stall_mem;
    logic        flush_id;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(
        .TIMEOUT   (16),
        .BR_PENALTY(3),
        .CNTW      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ropa       (id_ropa),
        .id_ropb       (id_ropb),
        .id_ropa_is_reg(id_ropa_is_reg),
        .id_ropb_is_reg(id_ropb_is_reg),
        .id_branch     (id_branch),
        .ex_valid      (ex_valid),
        .ex_memrd      (ex_memrd),
        .ex_rd         (ex_rd),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .bubble_ex     (bubble_ex),
        .stall_mem     (stall_mem),
        .flush_id      (flush_id),
        .mem_timeout   (mem_timeout),
        .stall_count   (stall_count),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {stall_if, stall_id, bubble_ex, stall_mem, flush_id}.
    function automatic logic [4:0] outs();
        return {stall_if, stall_id, bubble_ex, stall_mem, flush_id};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_ropa = 0; id_ropb = 0; id_ropa_is_reg = 0; id_ropb_is_reg = 0;
        id_branch = 0; ex_valid = 0; ex_memrd = 0; ex_rd = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        #3;
        chk("reset_outs", {27'd0, outs()}, 32'd0);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_count", {16'd0, stall_count}, 32'd0);
        chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);

        // Hazard inputs active during reset must not reach the outputs.
        mem_req = 1; id_valid = 1; id_branch = 1; ex_valid = 1; ex_memrd = 1;
        ex_rd = 4'd3; id_ropb = 4'd3; id_ropb_is_reg = 1;
        #1;
        chk("reset_outs_busy", {27'd0, outs()}, 32'd0);
        tick();
        tick();
        chk("reset_state_clk", {30'd0, state}, 32'd0);
        chk("reset_count_clk", {16'd0, stall_count}, 32'd0);
        clear_inputs();
        rst_n = 1;
        #2;
        chk("post_reset_outs", {27'd0, outs()}, 32'd0);
        tick();

        // Load-use on operand B.
        ex_valid = 1; ex_memrd = 1; ex_rd = 4'd3; id_valid = 1;
        id_ropa = 4'd5; id_ropa_is_reg = 1; id_ropb = 4'd3; id_ropb_is_reg = 1;
        #2;
        chk("loaduse_outs", {27'd0, outs()}, 32'b11100);
        tick();
        chk("loaduse_count", {16'd0, stall_count}, 32'd1);
        chk("loaduse_state", {30'd0, state}, 32'd0);
        ex_memrd = 0;
        #2;
        chk("loaduse_release", {27'd0, outs()}, 32'd0);

        // Masked load-use cases.
        ex_memrd = 1; ex_rd = 4'd15; id_ropb = 4'd15;
        #1;
        chk("mask_r15", {27'd0, outs()}, 32'd0);
        ex_rd = 4'd3; id_ropb = 4'd3; id_ropb_is_reg = 0;
        #1;
        chk("mask_isreg", {27'd0, outs()}, 32'd0);
        id_ropa = 4'd3;
        #1;
        chk("loaduse_ropa", {27'd0, outs()}, 32'b11100);
        tick();
        chk("loaduse_ropa_count", {16'd0, stall_count}, 32'd2);
        clear_inputs();

        // Taken branch, penalty 3: flush 3 cycles, state 0 -> 2 -> 2 -> 0.
        id_valid = 1; id_branch = 1;
        #2;
        chk("br_c1_outs", {27'd0, outs()}, 32'b00001);
        tick();
        chk("br_c1_state", {30'd0, state}, 32'd2);
        id_branch = 0;
        #2;
        chk("br_c2_outs", {27'd0, outs()}, 32'b00001);
        tick();
        chk("br_c2_state", {30'd0, state}, 32'd2);
        #2;
        chk("br_c3_outs", {27'd0, outs()}, 32'b00001);
        tick();
        chk("br_c3_state", {30'd0, state}, 32'd0);
        #2;
        chk("br_done_outs", {27'd0, outs()}, 32'd0);
        chk("br_count", {16'd0, stall_count}, 32'd2);
        clear_inputs();

        // Memory wait of 4 cycles.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("memwait_outs_%0d", i), {27'd0, outs()}, 32'b11010);
            tick();
            chk($sformatf("memwait_state_%0d", i), {30'd0, state}, 32'd1);
        end
        chk("memwait_count", {16'd0, stall_count}, 32'd6);
        mem_ready = 1;
        #2;
        chk("memwait_ready_outs", {27'd0, outs()}, 32'd0);
        tick();
        chk("memwait_done_state", {30'd0, state}, 32'd0);
        chk("memwait_done_count", {16'd0, stall_count}, 32'd6);
        clear_inputs();

        // Memory stall, load-use and branch together: memory stall wins.
        ex_valid = 1; ex_memrd = 1; ex_rd = 4'd3; id_valid = 1;
        id_ropb = 4'd3; id_ropb_is_reg = 1; id_branch = 1;
        mem_req = 1; mem_ready = 0;
        #2;
        chk("simul_outs", {27'd0, outs()}, 32'b11010);
        tick();
        chk("simul_state", {30'd0, state}, 32'd1);
        mem_ready = 1; ex_memrd = 0;
        #2;
        chk("simul_ready_outs", {27'd0, outs()}, 32'd0);
        tick();
        chk("simul_ready_state", {30'd0, state}, 32'd0);
        mem_req = 0; mem_ready = 0;
        #2;
        chk("simul_br_outs", {27'd0, outs()}, 32'b00001);
        tick();
        chk("simul_br_state", {30'd0, state}, 32'd2);
        id_branch = 0;
        #2;
        chk("simul_br_c2", {27'd0, outs()}, 32'b00001);
        tick();
        #2;
        chk("simul_br_c3", {27'd0, outs()}, 32'b00001);
        tick();
        chk("simul_br_end", {30'd0, state}, 32'd0);
        chk("simul_count", {16'd0, stall_count}, 32'd7);
        clear_inputs();

        // Reset in the middle of a branch flush.
        id_valid = 1; id_branch = 1;
        tick();
        chk("rstbr_state_before", {30'd0, state}, 32'd2);
        id_branch = 0;
        #1;
        rst_n = 0;
        #1;
        chk("rstbr_outs", {27'd0, outs()}, 32'd0);
        chk("rstbr_state", {30'd0, state}, 32'd0);
        chk("rstbr_count", {16'd0, stall_count}, 32'd0);
        tick();
        rst_n = 1;
        #2;
        chk("rstbr_after_outs", {27'd0, outs()}, 32'd0);
        tick();
        chk("rstbr_after_state", {30'd0, state}, 32'd0);
        clear_inputs();

        // Timeout: memory never answers.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 16; i++) begin
            #2;
            chk($sformatf("to_stall_%0d", i), {27'd0, outs()}, 32'b11010);
            chk($sformatf("to_flag_%0d", i), {31'd0, mem_timeout}, 32'd0);
            tick();
        end
        chk("to_flag_set", {31'd0, mem_timeout}, 32'd1);
        chk("to_state", {30'd0, state}, 32'd0);
        chk("to_count", {16'd0, stall_count}, 32'd16);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("to_released_%0d", i), {27'd0, outs()}, 32'd0);
            tick();
            chk($sformatf("to_sticky_%0d", i), {31'd0, mem_timeout}, 32'd1);
        end
        chk("to_count_hold", {16'd0, stall_count}, 32'd16);

        // Reset in the middle of a memory wait clears the sticky flag too.
        rst_n = 0;
        #1;
        chk("rstmem_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("rstmem_outs", {27'd0, outs()}, 32'd0);
        tick();
        rst_n = 1;
        #2;
        chk("rstmem_restall", {27'd0, outs()}, 32'b11010);
        tick();
        chk("rstmem_state", {30'd0, state}, 32'd1);
        rst_n = 0;
        #1;
        chk("rstmem_wait_abort", {30'd0, state}, 32'd0);
        clear_inputs();
        tick();
        rst_n = 1;
        #2;
        chk("rstmem_after_outs", {27'd0, outs()}, 32'd0);
        tick();
        chk("rstmem_after_state", {30'd0, state}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16; maximum MEM_WAIT cycles before the memory stall is abandoned (range 2..255).
REQ-002 SHALL have parameter BR_PENALTY, default 1; number of flush cycles per taken branch (range 1..15).
REQ-003 SHALL have parameter CNTW, default 16; stall counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  ID stage holds a valid instruction.
REQ-008 id_ropa, id_ropb  in  4 each  ID source register addresses (RopA/RopB from the decoder).
REQ-009 id_ropa_is_reg, id_ropb_is_reg  in  1 each  operand is a register, not zero or immediate.
REQ-010 id_branch  in  1  decoder selBRANCH.
REQ-011 ex_valid, ex_memrd  in  1 each  EX stage valid; EX instruction is a load.
REQ-012 ex_rd  in  4  EX destination register.
REQ-013 mem_req, mem_ready  in  1 each  MEM stage memory request; memory acknowledge.
REQ-014 stall_if, stall_id  out  1 each  hold PC and IF/ID; hold ID/EX.
REQ-015 bubble_ex  out  1  insert NOP into EX.
REQ-016 stall_mem  out  1  freeze EX/MEM/WB.
REQ-017 flush_id  out  1  squash the IF/ID instruction.
REQ-018 mem_timeout  out  1  sticky memory-timeout flag.
REQ-019 stall_count  out  CNTW  saturating count of stalled cycles.
REQ-020 state  out  2  FSM state: RUN=0, MEM_WAIT=1, BR_FLUSH=2.

Function
REQ-021 memstall SHALL be mem_req & ~mem_ready & ~mem_timeout, evaluated in any state; when true, stall_if, stall_id and stall_mem SHALL be 1 in the same cycle, and bubble_ex and flush_id SHALL be 0.
REQ-022 loaduse SHALL be ex_valid & ex_memrd & id_valid & ex_rd!=15 & ((id_ropa_is_reg & id_ropa==ex_rd) | (id_ropb_is_reg & id_ropb==ex_rd)).
REQ-023 In RUN with ~memstall & loaduse, the block SHALL drive stall_if=stall_id=bubble_ex=1 in the same cycle, with no state change; id_branch SHALL be ignored that cycle.
REQ-024 In RUN with ~memstall & ~loaduse & id_valid & id_branch, the block SHALL drive flush_id=1 in the same cycle.
REQ-025 For the case in REQ-024 with BR_PENALTY>1, the block SHALL enter BR_FLUSH with br_cnt=BR_PENALTY-1.
REQ-026 In BR_FLUSH, flush_id SHALL be 1 and br_cnt SHALL decrement each cycle; the block SHALL return to RUN on the cycle br_cnt==1, and loaduse and id_branch SHALL be ignored.
REQ-027 In any state with memstall and ~mem_timeout, the block SHALL move to MEM_WAIT; br_cnt SHALL be frozen and retained.
REQ-028 On RUN->MEM_WAIT, wait_cnt SHALL load 1.
REQ-029 In MEM_WAIT, wait_cnt SHALL increment each memstall cycle.
REQ-030 When mem_ready=1 in MEM_WAIT, the block SHALL leave MEM_WAIT to BR_FLUSH if br_cnt!=0, else to RUN.
REQ-031 In MEM_WAIT, when memstall & wait_cnt==TIMEOUT-1, mem_timeout SHALL set to 1 on that edge and the block SHALL return to RUN; stalls SHALL be released from the next cycle.
REQ-032 mem_timeout SHALL clear only on reset; while it is 1, memstall SHALL be forced to 0.
REQ-033 Priority SHALL be memstall > loaduse > branch.
REQ-034 stall_count SHALL increment on every cycle with stall_if=1 and hold at 2^CNTW-1.
REQ-035 Unused state encoding 3 SHALL transition to RUN on the next edge.
REQ-036 Outputs other than state, mem_timeout and stall_count SHALL be combinational.

Reset
REQ-037 While rst_n=0, all outputs SHALL be 0, state SHALL be RUN, and wait_cnt, br_cnt and stall_count SHALL be 0, independent of clk and of other inputs.
REQ-038 Reset asserted mid-MEM_WAIT or mid-BR_FLUSH SHALL abort the operation and SHALL leave no residual flush or stall after rst_n rises.

Verification
REQ-039 Load-use: ex_memrd=1, ex_rd=3, id_ropb=3, id_ropb_is_reg=1 -> one cycle stall_if=stall_id=bubble_ex=1; stall_count=1.
REQ-040 Masked load-use: ex_rd=15, or the matching operand has is_reg=0 -> no stall.
REQ-041 Branch with BR_PENALTY=3: id_branch=1 -> flush_id high for exactly 3 cycles; state 0->2->2->0.
REQ-042 Memory wait: mem_req=1 with mem_ready low for 4 cycles -> stall_mem=1 for those 4 cycles, state=1 during the wait, RUN after mem_ready=1; stall_count=4.
REQ-043 Timeout (TIMEOUT=16): mem_ready never asserted -> mem_timeout=1 after 16 stalled cycles; stalls drop and stay 0 while mem_req stays 1.
REQ-044 Simultaneous events: loaduse, id_branch and memstall in one cycle -> only memstall outputs; the branch is flushed after mem_ready. Reset mid-BR_FLUSH -> all outputs 0.
